// File: rtl/multiplier_arbiter.sv
// Round-robin front end that shares one pipelined in-order multiplier among NUM_REQ
// requesters, tagging each issue so its product is steered back to the right requester.
module multiplier_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int INPUT_DATA_WIDTH  = 32,
    parameter int OUTPUT_DATA_WIDTH = 64,
    parameter int LATENCY           = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_in2,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [OUTPUT_DATA_WIDTH-1:0]        rsp_out,
    output logic [INPUT_DATA_WIDTH-1:0]         mul_in1,
    output logic [INPUT_DATA_WIDTH-1:0]         mul_in2,
    output logic                                mul_inputs_valid,
    input  logic [OUTPUT_DATA_WIDTH-1:0]        mul_out,
    input  logic                                mul_output_valid,
    output logic                                busy,
    output logic                                err_unexpected
);

    localparam int DEPTH = LATENCY + 2;
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] grant_idx;
    logic             grant_found;
    logic [TAG_W:0]   pos;
    logic             push;
    logic             pop;

    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);

    // Handshake: requester i transfers one operand pair on a rising edge where
    // req_valid[i] && req_ready[i]; req_ready is only ever raised on a valid requester.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        pos         = '0;
        // Scan downwards so the lowest offset from rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + (TAG_W+1)'(k);
            if (pos >= (TAG_W+1)'(NUM_REQ)) begin
                pos = pos - (TAG_W+1)'(NUM_REQ);
            end
            if (req_valid[pos[TAG_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = pos[TAG_W-1:0];
            end
        end
        req_ready = '0;
        if (grant_found && !fifo_full && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign push = |req_ready;
    assign pop  = mul_output_valid && !fifo_empty;
    assign busy = !fifo_empty || mul_inputs_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr           <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            mul_in1          <= '0;
            mul_in2          <= '0;
            mul_inputs_valid <= 1'b0;
            rsp_valid        <= '0;
            rsp_out          <= '0;
            err_unexpected   <= 1'b0;
        end else begin
            mul_inputs_valid <= push;
            if (push) begin
                mul_in1         <= req_in1[grant_idx*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
                mul_in2         <= req_in2[grant_idx*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
                tag_mem[wr_ptr] <= grant_idx;
                wr_ptr          <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                rr_ptr          <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end

            rsp_valid <= '0;
            if (pop) begin
                rsp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
                rsp_out   <= mul_out;
                rd_ptr    <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end

            // A product with no tag to claim it is a multiplier protocol violation.
            if (mul_output_valid && fifo_empty) begin
                err_unexpected <= 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: a queue-based multiplier model, a queue-based arbiter
// model compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_multiplier_arbiter;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int OW    = 64;
    localparam int L     = 3;
    localparam int DEPTH = L + 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_in1 = '0;
    logic [N*W-1:0]  req_in2 = '0;
    logic [N-1:0]    rsp_valid;
    logic [OW-1:0]   rsp_out;
    logic [W-1:0]    mul_in1;
    logic [W-1:0]    mul_in2;
    logic            mul_inputs_valid;
    logic [OW-1:0]   mul_out = '0;
    logic            mul_output_valid = 1'b0;
    logic            busy;
    logic            err_unexpected;

    int vectors = 0;
    int miscompares = 0;

    multiplier_arbiter #(
        .NUM_REQ(N), .INPUT_DATA_WIDTH(W), .OUTPUT_DATA_WIDTH(OW), .LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .rsp_valid(rsp_valid), .rsp_out(rsp_out),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_inputs_valid(mul_inputs_valid),
        .mul_out(mul_out), .mul_output_valid(mul_output_valid),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- multiplier model ----------------
    int            cyc = 0;
    logic          hold = 1'b0;
    logic          inject = 1'b0;
    logic [OW-1:0] mq_prod[$];
    int            mq_due[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            mq_prod.delete();
            mq_due.delete();
            mul_output_valid <= 1'b0;
        end else begin
            if (mul_inputs_valid) begin
                mq_prod.push_back(OW'(mul_in1) * OW'(mul_in2));
                mq_due.push_back(cyc + L - 1);
            end
            if (inject) begin
                mul_output_valid <= 1'b1;
                mul_out          <= 64'hdead_beef_0bad_f00d;
            end else if (!hold && mq_due.size() > 0 && mq_due[0] <= cyc) begin
                mul_output_valid <= 1'b1;
                mul_out          <= mq_prod.pop_front();
                void'(mq_due.pop_front());
            end else begin
                mul_output_valid <= 1'b0;
            end
        end
    end

    // ---------------- arbiter reference model ----------------
    logic [1:0]    exp_q[$];
    int            m_ptr = 0;
    logic          m_on = 1'b0;
    logic          e_miv = 1'b0;
    logic [W-1:0]  e_in1 = '0;
    logic [W-1:0]  e_in2 = '0;
    logic [N-1:0]  e_rsp_valid = '0;
    logic [OW-1:0] e_rsp_out = '0;
    logic          e_err = 1'b0;

    function automatic int pick(input logic [N-1:0] v, input int p, input int qn);
        if (qn >= DEPTH) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (reset) begin
            m_on = 1'b1;
            m_ptr = 0;
            exp_q.delete();
            e_miv = 1'b0;
            e_in1 = '0;
            e_in2 = '0;
            e_rsp_valid = '0;
            e_rsp_out = '0;
            e_err = 1'b0;
        end else if (m_on) begin
            g = pick(req_valid, m_ptr, exp_q.size());
            e_rsp_valid = '0;
            if (mul_output_valid) begin
                if (exp_q.size() > 0) begin
                    e_rsp_valid = N'(1) << exp_q.pop_front();
                    e_rsp_out = mul_out;
                end else begin
                    e_err = 1'b1;
                end
            end
            e_miv = (g >= 0);
            if (g >= 0) begin
                exp_q.push_back(2'(g));
                e_in1 = req_in1[g*W +: W];
                e_in2 = req_in2[g*W +: W];
                m_ptr = (g + 1) % N;
            end
        end
    end

    // ---------------- per-cycle compare and event logs ----------------
    longint hs_cyc[$], hs_g[$], iv_cyc[$], iv_in1[$], iv_in2[$], rsp_cyc[$], rsp_vec[$], rsp_dat[$];

    always @(negedge clk) begin
        int g;
        #2;
        if (m_on) begin
            g = pick(req_valid, m_ptr, exp_q.size());
            check("req_ready", 64'(req_ready), (reset || g < 0) ? 64'd0 : (64'd1 << g));
            check("mul_inputs_valid", 64'(mul_inputs_valid), 64'(e_miv));
            check("mul_in1", 64'(mul_in1), 64'(e_in1));
            check("mul_in2", 64'(mul_in2), 64'(e_in2));
            check("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
            if (e_rsp_valid != '0) check("rsp_out", rsp_out, e_rsp_out);
            check("busy", 64'(busy), 64'((exp_q.size() != 0) || e_miv));
            check("err_unexpected", 64'(err_unexpected), 64'(e_err));
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                hs_cyc.push_back(cyc + 1);
                hs_g.push_back(i);
            end
        end
        if (mul_inputs_valid) begin
            iv_cyc.push_back(cyc);
            iv_in1.push_back(longint'(mul_in1));
            iv_in2.push_back(longint'(mul_in2));
        end
        if (rsp_valid != '0) begin
            rsp_cyc.push_back(cyc);
            rsp_vec.push_back(longint'(rsp_valid));
            rsp_dat.push_back(longint'(rsp_out));
        end
    end

    function automatic longint at(input longint q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        hs_cyc.delete(); hs_g.delete();
        iv_cyc.delete(); iv_in1.delete(); iv_in2.delete();
        rsp_cyc.delete(); rsp_vec.delete(); rsp_dat.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        hold = 1'b0;
        inject = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_in1[i*W +: W] = a;
        req_in2[i*W +: W] = b;
    endtask

    // Hold mask valid until n handshakes have occurred, then drop all valids.
    task automatic hold_grants(input logic [N-1:0] mask, input int n);
        int got = 0;
        int guard = 0;
        @(negedge clk);
        req_valid = mask;
        while (got < n && guard < 200) begin
            #1;
            if (|(req_valid & req_ready)) got++;
            @(negedge clk);
            guard++;
        end
        req_valid = '0;
        if (got < n) check("grant_timeout", 64'(got), 64'(n));
    endtask

    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        set_ops(i, a, b);
        hold_grants(N'(1) << i, 1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((busy || mq_due.size() > 0 || mul_output_valid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("idle_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin
        int n_before;
        repeat (3) @(negedge clk);
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_miv", 64'(mul_inputs_valid), 64'd0);
        check("rst_mul_in1", 64'(mul_in1), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_out", rsp_out, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_unexpected), 64'd0);
        reset = 1'b0;

        // single request from requester 2
        clear_logs();
        send(2, 7, 6);
        wait_idle();
        check("single_iv_count", 64'(iv_cyc.size()), 64'd1);
        check("single_iv_cycle", at(iv_cyc, 0), at(hs_cyc, 0));
        check("single_in1", at(iv_in1, 0), 64'd7);
        check("single_in2", at(iv_in2, 0), 64'd6);
        check("single_rsp_vec", at(rsp_vec, 0), 64'b0100);
        check("single_rsp_out", at(rsp_dat, 0), 64'd42);
        check("single_latency", at(rsp_cyc, 0), at(hs_cyc, 0) + L + 1);
        check("single_busy_idle", 64'(busy), 64'd0);

        // fairness: all four requesters held for 8 grants
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), 10);
        hold_grants('1, 8);
        wait_idle();
        for (int k = 0; k < 8; k++) begin
            check("fair_grant", at(hs_g, k), 64'(k % N));
            if (k > 0) check("fair_back_to_back", at(iv_cyc, k), at(iv_cyc, 0) + k);
            check("fair_rsp_vec", at(rsp_vec, k), 64'd1 << (k % N));
            check("fair_rsp_out", at(rsp_dat, k), 64'(10 * (k % N + 1)));
        end

        // pointer skip: ptr=1 after one grant to 0, then only 0 and 3 request
        do_reset();
        send(0, 2, 3);
        clear_logs();
        set_ops(3, 4, 5);
        hold_grants(4'b1001, 3);
        wait_idle();
        check("skip_g0", at(hs_g, 0), 64'd3);
        check("skip_g1", at(hs_g, 1), 64'd0);
        check("skip_g2", at(hs_g, 2), 64'd3);

        // full stall: multiplier withholds outputs while requester 0 streams
        do_reset();
        clear_logs();
        hold = 1'b1;
        set_ops(0, 9, 11);
        @(negedge clk);
        req_valid = 4'b0001;
        repeat (12) @(negedge clk);
        n_before = hs_g.size();
        hold = 1'b0;
        repeat (4) @(negedge clk);
        req_valid = '0;
        wait_idle();
        check("stall_handshakes", 64'(n_before), 64'(DEPTH));
        check("stall_no_tag_lost", 64'(rsp_vec.size()), 64'(hs_g.size()));
        check("stall_rsp_out", at(rsp_dat, 0), 64'd99);

        // spurious product with nothing outstanding
        do_reset();
        clear_logs();
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        check("spurious_err", 64'(err_unexpected), 64'd1);
        check("spurious_no_rsp", 64'(rsp_vec.size()), 64'd0);

        // reset with three operations in flight
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) set_ops(i, 3, 5);
        hold_grants('1, 3);
        reset = 1'b1;
        @(negedge clk);
        #3;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_miv", 64'(mul_inputs_valid), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        clear_logs();
        hold_grants('1, 1);
        wait_idle();
        check("midrst_ptr_zero", at(hs_g, 0), 64'd0);
        check("midrst_rsp_vec", at(rsp_vec, 0), 64'd1);
        check("midrst_rsp_out", at(rsp_dat, 0), 64'd15);
        check("midrst_err", 64'(err_unexpected), 64'd0);

        // random traffic with occasional multiplier stalls
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 0) set_ops(i, $urandom, $urandom);
                else set_ops(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            end
            hold = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        req_valid = '0;
        hold = 1'b0;
        wait_idle();
        check("random_err_clear", 64'(err_unexpected), 64'd0);
        check("random_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
